// File: rtl/div_seq_ctrl.sv
// Sequential RV32M divider: restoring shift-subtract, one quotient bit per cycle.
// Signs are stripped at accept and reapplied after the final iteration.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] rd_o,
    input  logic             ack_i
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rem_sel_q, rem_sel_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rd_q, rd_d;

    logic             sgn;
    logic             ovf;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    always_comb begin
        sgn   = ~op_i[0];
        a_abs = (sgn && rs1_i[WIDTH-1]) ? -rs1_i : rs1_i;
        b_abs = (sgn && rs2_i[WIDTH-1]) ? -rs2_i : rs2_i;
        ovf   = sgn && (rs1_i == {1'b1, {(WIDTH-1){1'b0}}})
                    && (rs2_i == '1);

        // Top bit of the WIDTH+1-bit difference is the borrow
        trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
        qbit  = ~trial[WIDTH];
        rem_n = qbit ? trial[WIDTH-1:0]
                     : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        quo_n = {dvd_q[WIDTH-2:0], qbit};

        state_d   = state_q;
        count_d   = count_q;
        rem_sel_d = rem_sel_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rd_d      = rd_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    rem_sel_d = op_i[1];
                    negq_d    = sgn & (rs1_i[WIDTH-1] ^ rs2_i[WIDTH-1]);
                    negr_d    = sgn & rs1_i[WIDTH-1];
                    rem_d     = '0;
                    dvd_d     = a_abs;
                    dvs_d     = b_abs;
                    count_d   = '0;
                    if (rs2_i == '0) begin
                        rd_d    = op_i[1] ? rs1_i : '1;
                        state_d = DONE;
                    end else if (ovf) begin
                        rd_d    = op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_n;
                    dvd_d   = quo_n;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH-1)) begin
                        state_d = DONE;
                        if (rem_sel_q)
                            rd_d = negr_q ? -rem_n : rem_n;
                        else
                            rd_d = negq_q ? -quo_n : quo_n;
                    end
                end
            end
            DONE: begin
                if (flush_i || ack_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_sel_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_sel_q <= rem_sel_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rd_q      <= rd_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign valid_o = (state_q == DONE);
    assign rd_o    = rd_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: results, latency, handshake, flush, reset.
module tb_div_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] rd_o;
    logic        ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .busy_o(busy_o), .valid_o(valid_o), .rd_o(rd_o), .ack_i(ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h5555_0000;
    endtask

    // edges after the accept edge until valid_o; -1 on timeout
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 100) begin
            tick();
            n++;
        end
        if (!valid_o) n = -1;
    endtask

    task automatic pulse_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #12;
        checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100 || rd_o !== 32'h0) begin
            errors++;
            $display("FAIL reset rdy/busy/vld=%b%b%b rd=%h exp 100 rd=0",
                     ready_o, busy_o, valid_o, rd_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_signed();
        int n;
        accept(2'b00, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL div_calc busy=%b valid=%b exp 1 0", busy_o, valid_o);
        end
        wait_valid(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL div_lat got %0d exp 32", n);
        end
        checks++;
        if (rd_o !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_m7_2 got %h exp fffffffd", rd_o);
        end
        pulse_ack();
        accept(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_valid(n);
        checks++;
        if (n !== 32 || rd_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rem_m7_2 got %h lat %0d exp ffffffff lat 32",
                     rd_o, n);
        end
        pulse_ack();
    endtask

    task automatic test_unsigned();
        int n;
        accept(2'b11, 32'hFFFF_FFFF, 32'h10);
        wait_valid(n);
        checks++;
        if (rd_o !== 32'h0000_000F) begin
            errors++;
            $display("FAIL remu got %h exp 0000000f", rd_o);
        end
        pulse_ack();
    endtask

    task automatic test_div_zero();
        int n;
        accept(2'b00, 32'h1234, 32'h0);
        wait_valid(n);
        checks++;
        if (n !== 0 || rd_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div0 got %h lat %0d exp ffffffff lat 0", rd_o, n);
        end
        pulse_ack();
        accept(2'b10, 32'h1234, 32'h0);
        wait_valid(n);
        checks++;
        if (n !== 0 || rd_o !== 32'h0000_1234) begin
            errors++;
            $display("FAIL rem0 got %h lat %0d exp 00001234 lat 0", rd_o, n);
        end
        pulse_ack();
    endtask

    task automatic test_overflow();
        int n;
        accept(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid(n);
        checks++;
        if (n !== 0 || rd_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ovf_div got %h lat %0d exp 80000000 lat 0", rd_o, n);
        end
        pulse_ack();
        accept(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid(n);
        checks++;
        if (n !== 0 || rd_o !== 32'h0) begin
            errors++;
            $display("FAIL ovf_rem got %h lat %0d exp 0 lat 0", rd_o, n);
        end
        pulse_ack();
    endtask

    task automatic test_hold_ack();
        int n;
        int bad = 0;
        accept(2'b01, 32'hFFFF_FFFF, 32'h10);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid_o !== 1'b1 || rd_o !== 32'h0FFF_FFFF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold got %0d unstable cycles exp 0 (rd=%h)", bad, rd_o);
        end
        pulse_ack();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_ready ready=%b valid=%b exp 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        accept(2'b01, 32'h1000, 32'd3);
        repeat (10) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0
            || rd_o !== 32'h0FFF_FFFF) begin
            errors++;
            $display("FAIL flush rdy=%b busy=%b vld=%b rd=%h exp 1 0 0 0fffffff",
                     ready_o, busy_o, valid_o, rd_o);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_novalid got %0d valid cycles exp 0", seen);
        end
        op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd0;
        start_i = 1'b1; flush_i = 1'b1;
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle ready=%b busy=%b exp 1 0", ready_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        accept(2'b00, 32'd100, 32'd7);
        repeat (5) tick();
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100 || rd_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid rdy/busy/vld=%b%b%b rd=%h exp 100 rd=0",
                     ready_o, busy_o, valid_o, rd_o);
        end
        #1 rst_i = 1'b0;
        repeat (40) tick();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_after valid=%b ready=%b exp 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        op_i = 2'b00; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1;
        tick();
        wait_valid(n);
        checks++;
        if (n !== 32 || rd_o !== 32'd14) begin
            errors++;
            $display("FAIL b2b_div got %0d lat %0d exp 14 lat 32", rd_o, n);
        end
        ack_i = 1'b1; op_i = 2'b10;
        tick();
        ack_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack ready=%b valid=%b exp 1 0", ready_o, valid_o);
        end
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b exp 1", busy_o);
        end
        wait_valid(n);
        checks++;
        if (n !== 32 || rd_o !== 32'd2) begin
            errors++;
            $display("FAIL b2b_rem got %0d lat %0d exp 2 lat 32", rd_o, n);
        end
        pulse_ack();
    endtask

    task automatic test_divu();
        int n;
        accept(2'b01, 32'hFFFF_FFFF, 32'h10);
        wait_valid(n);
        checks++;
        if (rd_o !== 32'h0FFF_FFFF) begin
            errors++;
            $display("FAIL divu got %h exp 0fffffff", rd_o);
        end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_divu();
        test_unsigned();
        test_div_zero();
        test_overflow();
        test_hold_ack();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
